// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serial memory sequencer
package mem_ctrl_pkg;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [31:0] IO_BASE = 32'h30000;
    localparam logic [1:0] IO_SEL = 2'b11;
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        return s == SIZE_B ? 3'd1 : s == SIZE_H ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF/MEM requests onto a byte-serial RAM/IO bus with overlapped reads
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o,
    output logic              busy_o
);
    state_t state_q, state_d;
    owner_t own_q, own_d;
    logic [2:0] n_q, n_d, iss_q, iss_d, cap_q, cap_d;
    logic v1_q, v1_d, v2_q, v2_d, stall_q;
    logic [ADDR_W-1:0] base_q, base_d, a_q, a_d;
    logic [31:0] buf_q, buf_d, wdata_q, wdata_d, if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic [7:0] dout_q, dout_d;
    logic wr_q, wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;

    function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] k);
        return w[k*8 +: 8];
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] k, input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[k*8 +: 8] = b;
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        own_d = own_q;
        n_d = n_q;
        iss_d = iss_q;
        cap_d = cap_q;
        v1_d = v1_q;
        v2_d = v2_q;
        base_d = base_q;
        a_d = a_q;
        buf_d = buf_q;
        wdata_d = wdata_q;
        if_data_d = if_data_q;
        mem_rdata_d = mem_rdata_q;
        dout_d = dout_q;
        wr_d = wr_q;
        if_done_d = if_done_q;
        mem_done_d = mem_done_q;
        if (rdy) begin
            if_done_d = 1'b0;
            mem_done_d = 1'b0;
            wr_d = 1'b0;
            unique case (state_q)
                IDLE: if (!if_done_q && !mem_done_q && (mem_req_i || if_req_i)) begin
                    own_d = mem_req_i ? OWN_MEM : OWN_IF;
                    state_d = mem_req_i && mem_we_i ? WR : RD;
                    n_d = mem_req_i ? size_bytes(mem_size_i) : 3'd4;
                    base_d = mem_req_i ? mem_addr_i : if_addr_i;
                    wdata_d = mem_wdata_i;
                    buf_d = '0;
                    cap_d = 3'd0;
                    iss_d = 3'd1;
                    v1_d = 1'b1;
                    v2_d = 1'b0;
                    a_d = base_d;
                    wr_d = mem_req_i && mem_we_i;
                    dout_d = wr_d ? lane_get(mem_wdata_i, 2'd0) : dout_q;
                end
                RD: if (own_q == OWN_IF && if_cancel_i) begin
                    state_d = IDLE;
                end else if (stall_q) begin
                    // bytes in flight during the stall were never captured: restart from the oldest
                    a_d = base_q + ADDR_W'(cap_q);
                    iss_d = cap_q + 3'd1;
                    v1_d = 1'b1;
                    v2_d = 1'b0;
                end else begin
                    v2_d = v1_q;
                    v1_d = iss_q < n_q;
                    if (iss_q < n_q) begin
                        a_d = base_q + ADDR_W'(iss_q);
                        iss_d = iss_q + 3'd1;
                    end
                    if (v2_q) begin
                        buf_d = lane_put(buf_q, cap_q[1:0], mem_din_i);
                        cap_d = cap_q + 3'd1;
                        if (cap_q == n_q - 3'd1) begin
                            state_d = IDLE;
                            if_done_d = own_q == OWN_IF;
                            mem_done_d = own_q == OWN_MEM;
                            if_data_d = own_q == OWN_IF ? buf_d : if_data_q;
                            mem_rdata_d = own_q == OWN_MEM ? buf_d : mem_rdata_q;
                        end
                    end
                end
                WR: if (iss_q < n_q) begin
                    a_d = base_q + ADDR_W'(iss_q);
                    dout_d = lane_get(wdata_q, iss_q[1:0]);
                    wr_d = 1'b1;
                    iss_d = iss_q + 3'd1;
                end else begin
                    state_d = IDLE;
                    mem_done_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q <= OWN_IF;
            n_q <= '0;
            iss_q <= '0;
            cap_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            stall_q <= 1'b0;
            base_q <= '0;
            a_q <= '0;
            buf_q <= '0;
            wdata_q <= '0;
            if_data_q <= '0;
            mem_rdata_q <= '0;
            dout_q <= '0;
            wr_q <= 1'b0;
            if_done_q <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q <= own_d;
            n_q <= n_d;
            iss_q <= iss_d;
            cap_q <= cap_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            stall_q <= !rdy;
            base_q <= base_d;
            a_q <= a_d;
            buf_q <= buf_d;
            wdata_q <= wdata_d;
            if_data_q <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            dout_q <= dout_d;
            wr_q <= wr_d;
            if_done_q <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    assign if_done_o = if_done_q;
    assign if_data_o = if_data_q;
    assign mem_done_o = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_dout_o = dout_q;
    assign mem_a_o = a_q;
    assign mem_wr_o = wr_q && rdy;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a synchronous byte RAM model
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic if_req = 1'b0, if_cancel = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [1:0] mem_size = '0;
    logic [7:0] mem_din = '0;
    logic if_done_o, mem_done_o, mem_wr_o, busy_o;
    logic [31:0] if_data_o, mem_rdata_o, mem_a_o;
    logic [7:0] mem_dout_o;
    logic [7:0] ram [0:65535];
    logic [31:0] wa [0:15];
    logic [7:0] wd [0:15];
    int wn = 0;
    int n_tests = 0;
    int n_fail = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_cancel_i(if_cancel),
        .if_done_o(if_done_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .mem_din_i(mem_din), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o),
        .mem_wr_o(mem_wr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a_o[15:0]];
        if (mem_wr_o) begin
            wa[wn[3:0]] <= mem_a_o;
            wd[wn[3:0]] <= mem_dout_o;
            wn <= wn + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0000] = 8'h41;
        ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22; ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_a", mem_a_o, 0);
        check("rst_wr", mem_wr_o, 0);
        check("rst_dones", {if_done_o, mem_done_o}, 0);
        check("rst_data", if_data_o | mem_rdata_o, 0);
        rst = 1'b1;
        @(negedge clk);
        // IF word read at 0x100
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("t1_addr", mem_a_o, 32'h100 + (k < 4 ? k : 3));
            check("t1_wr", mem_wr_o, 0);
            check("t1_done", if_done_o, k == 5);
        end
        check("t1_data", if_data_o, 32'h0000_0513);
        if_req = 1'b0;
        @(negedge clk);
        check("t1_idle", {busy_o, if_done_o}, 0);
        // MEM half store 0xBEEF to 0x2001
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'h2001; mem_wdata = 32'h0000_BEEF;
        @(negedge clk);
        check("t2_b0", {mem_wr_o, mem_a_o[15:0], mem_dout_o}, {1'b1, 16'h2001, 8'hEF});
        check("t2_done0", mem_done_o, 0);
        @(negedge clk);
        check("t2_b1", {mem_wr_o, mem_a_o[15:0], mem_dout_o}, {1'b1, 16'h2002, 8'hBE});
        @(negedge clk);
        check("t2_end", {mem_wr_o, mem_done_o}, 2'b01);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check("t2_wn", wn, 2);
        check("t2_log", {wa[0][15:0], wd[0], wa[1][15:0], wd[1]}, {16'h2001, 8'hEF, 16'h2002, 8'hBE});
        check("t2_idle", {busy_o, mem_done_o, mem_wr_o}, 0);
        // simultaneous IF and MEM byte load from IO region
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_size = 2'd0; mem_addr = 32'h30000;
        @(negedge clk);
        check("t3_a", mem_a_o, 32'h30000);
        @(negedge clk);
        check("t3_wait", {mem_done_o, if_done_o}, 0);
        @(negedge clk);
        check("t3_mdone", {mem_done_o, if_done_o}, 2'b10);
        check("t3_rdata", mem_rdata_o, 32'h0000_0041);
        mem_req = 1'b0;
        @(negedge clk);
        check("t3_bubble", {busy_o, mem_done_o, mem_a_o}, {2'b00, 32'h30000});
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("t3_if_a", mem_a_o, 32'h100 + (k < 4 ? k : 3));
            check("t3_if_done", if_done_o, k == 5);
        end
        check("t3_if_data", if_data_o, 32'h0000_0513);
        if_req = 1'b0;
        @(negedge clk);
        // IF read cancelled after byte 1, then MEM byte load
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        check("t4_a1", mem_a_o, 32'h101);
        if_cancel = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("t4_cancel", {busy_o, if_done_o}, 0);
        if_cancel = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h101;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            check("t4_busy", busy_o, k < 2);
            check("t4_nodone_if", if_done_o, 0);
            check("t4_mdone", mem_done_o, k == 2);
        end
        check("t4_rdata", mem_rdata_o, 32'h0000_0005);
        mem_req = 1'b0;
        @(negedge clk);
        // word read with a 3-cycle stall
        if_req = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t5_pre", mem_a_o, 32'h202);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_frozen", {busy_o, if_done_o, mem_wr_o, mem_a_o}, {3'b100, 32'h202});
        end
        rdy = 1'b1;
        @(negedge clk);
        check("t5_reissue", mem_a_o, 32'h201);
        @(negedge clk);
        check("t5_a2", mem_a_o, 32'h202);
        @(negedge clk);
        check("t5_a3", mem_a_o, 32'h203);
        @(negedge clk);
        check("t5_nodone", if_done_o, 0);
        @(negedge clk);
        check("t5_done", if_done_o, 1);
        check("t5_data", if_data_o, 32'h4433_2211);
        if_req = 1'b0;
        @(negedge clk);
        check("t5_wn", wn, 2);
        // reset during a word write after byte 2
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'hA1B2_C3D4;
        @(negedge clk);
        check("t6_b0", {mem_wr_o, mem_dout_o}, {1'b1, 8'hD4});
        @(negedge clk);
        @(negedge clk);
        check("t6_b2", {mem_wr_o, mem_a_o[15:0], mem_dout_o}, {1'b1, 16'h0302, 8'hB2});
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_ctl", {busy_o, mem_wr_o, mem_done_o, if_done_o}, 0);
        check("t6_rst_bus", {mem_a_o, mem_dout_o}, 0);
        check("t6_rst_data", {if_data_o, mem_rdata_o}, 0);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check("t6_after", {busy_o, mem_done_o}, 0);
        check("t6_wn", {wn, wd[4]}, {32'd5, 8'hB2});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
